lvt_cmd_packer: RTL and testbench

- Upstream feeder for the pipelined multi-port LVT memory.
- Accepts a serial stream of per-port read/write commands over valid/ready and packs them into one bundle per issue cycle (at most one command per port).
- Issues each bundle as a single cycle of memory port signals.
- Stalls bundles whose reads would hit writes still in flight in the memory pipeline.
- Returns read data as one packed response.

---
 rtl/lvt_cmd_pkg.sv | 30 +++
 rtl/lvt_wr_history.sv | 52 +++++
 rtl/lvt_cmd_packer.sv | 188 ++++++++++++++++++
 tb/tb_lvt_cmd_packer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvt_cmd_pkg.sv
// Shared types and default sizing for the LVT command packer.
package lvt_cmd_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF = 512;
  localparam int unsigned PORTS_DEF = 8;
  localparam int unsigned LAT_DEF   = 3;

  // $clog2 that never yields a zero-width field
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

  localparam int unsigned AW_DEF = clog2_safe(DEPTH_DEF);
  localparam int unsigned PW_DEF = clog2_safe(PORTS_DEF);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    ISSUE   = 2'd2
  } state_e;

  // One bundle slot; sized by the package defaults
  typedef struct packed {
    logic                 we;
    logic [AW_DEF-1:0]    addr;
    logic [WIDTH_DEF-1:0] wdata;
  } slot_t;

endpackage

// File: rtl/lvt_wr_history.sv
// Window of write addresses issued in the last LAT cycles, with a read-hit check.
module lvt_wr_history
  import lvt_cmd_pkg::*;
#(
  parameter int unsigned PORTS = PORTS_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned LAT   = LAT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic [PORTS*AW-1:0] wr_addr_i,
  input  logic [PORTS-1:0]    wr_vld_i,
  input  logic [PORTS*AW-1:0] rd_addr_i,
  input  logic [PORTS-1:0]    rd_mask_i,
  output logic                match_o
);

  logic [LAT-1:0][PORTS*AW-1:0] addr_q;
  logic [LAT-1:0][PORTS-1:0]    vld_q;

  // Age the window every cycle; non-issue cycles shift in an empty entry
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      vld_q  <= '0;
    end else begin
      addr_q[0] <= push_i ? wr_addr_i : '0;
      vld_q[0]  <= push_i ? wr_vld_i  : '0;
      for (int s = 1; s < LAT; s++) begin
        addr_q[s] <= addr_q[s-1];
        vld_q[s]  <= vld_q[s-1];
      end
    end
  end

  // Any masked read address equal to any live write address in the window
  always_comb begin
    match_o = 1'b0;
    for (int s = 0; s < LAT; s++) begin
      for (int w = 0; w < PORTS; w++) begin
        for (int r = 0; r < PORTS; r++) begin
          if (vld_q[s][w] && rd_mask_i[r] &&
              (addr_q[s][w*AW +: AW] == rd_addr_i[r*AW +: AW])) begin
            match_o = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/lvt_cmd_packer.sv
// Packs serial per-port commands into one-cycle bundles for the LVT memory.
module lvt_cmd_packer
  import lvt_cmd_pkg::*;
#(
  parameter  int unsigned WIDTH = WIDTH_DEF,
  parameter  int unsigned DEPTH = DEPTH_DEF,
  parameter  int unsigned PORTS = PORTS_DEF,
  parameter  int unsigned LAT   = LAT_DEF,
  localparam int unsigned AW    = clog2_safe(DEPTH),
  localparam int unsigned PW    = clog2_safe(PORTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [PW-1:0]          cmd_port,
  input  logic                   cmd_we,
  input  logic [AW-1:0]          cmd_addr,
  input  logic [WIDTH-1:0]       cmd_wdata,
  input  logic                   cmd_last,
  output logic [PORTS*AW-1:0]    mem_addr,
  output logic [PORTS-1:0]       mem_en,
  output logic [PORTS*WIDTH-1:0] mem_d,
  input  logic [PORTS*WIDTH-1:0] mem_q,
  output logic                   rsp_valid,
  output logic [PORTS-1:0]       rsp_mask,
  output logic [PORTS*WIDTH-1:0] rsp_data
);

  state_e                    state_q, state_d;
  slot_t [PORTS-1:0]         slot_q, slot_d;
  logic  [PORTS-1:0]         occ_q, occ_d;
  logic  [LAT-1:0][PORTS-1:0] rmask_q;
  logic                      rsp_valid_q;
  logic  [PORTS-1:0]         rsp_mask_q;
  logic  [PORTS*WIDTH-1:0]   rsp_data_q, rsp_data_c;

  logic                      block_c, accept_c, hist_match_c;
  logic  [PORTS*AW-1:0]      rd_addr_c, wr_addr_c;
  logic  [PORTS-1:0]         rd_mask_c, wr_vld_c, rd_now_c;

  // Slot conflict, same-address write pair, or read/write pair on one address
  always_comb begin
    block_c = occ_q[cmd_port];
    for (int j = 0; j < PORTS; j++) begin
      if (occ_q[j] && (slot_q[j].addr == AW_DEF'(cmd_addr)) && (cmd_we || slot_q[j].we)) begin
        block_c = 1'b1;
      end
    end
  end

  assign accept_c = (state_q == COLLECT) && cmd_valid && !block_c;

  // Bundle contents: fill on accept, drop everything once issued
  always_comb begin
    slot_d = slot_q;
    occ_d  = occ_q;
    if (state_q == ISSUE) begin
      occ_d = '0;
    end else if (accept_c) begin
      slot_d[cmd_port].we    = cmd_we;
      slot_d[cmd_port].addr  = AW_DEF'(cmd_addr);
      slot_d[cmd_port].wdata = WIDTH_DEF'(cmd_wdata);
      occ_d[cmd_port]        = 1'b1;
    end
  end

  // Hazard check uses the bundle as it will stand after this cycle's accept
  always_comb begin
    rd_addr_c = '0;
    rd_mask_c = '0;
    wr_addr_c = '0;
    wr_vld_c  = '0;
    rd_now_c  = '0;
    for (int j = 0; j < PORTS; j++) begin
      rd_addr_c[j*AW +: AW] = AW'(slot_d[j].addr);
      rd_mask_c[j]          = occ_d[j] && !slot_d[j].we;
      wr_addr_c[j*AW +: AW] = AW'(slot_q[j].addr);
      wr_vld_c[j]           = occ_q[j] && slot_q[j].we;
      rd_now_c[j]           = occ_q[j] && !slot_q[j].we;
    end
  end

  lvt_wr_history #(
    .PORTS(PORTS),
    .AW   (AW),
    .LAT  (LAT)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .push_i   (state_q == ISSUE),
    .wr_addr_i(wr_addr_c),
    .wr_vld_i (wr_vld_c),
    .rd_addr_i(rd_addr_c),
    .rd_mask_i(rd_mask_c),
    .match_o  (hist_match_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  // Next state: leave COLLECT on last, block or idle flush, then gate on hazards
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: begin
        if (cmd_valid ? (block_c || cmd_last) : (|occ_q)) begin
          state_d = hist_match_c ? HOLD : ISSUE;
        end
      end
      HOLD:    if (!hist_match_c) state_d = ISSUE;
      ISSUE:   state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Outputs: bundle drives the memory ports only in ISSUE; all quiet in reset
  always_comb begin
    cmd_ready = 1'b0;
    mem_addr  = '0;
    mem_en    = '0;
    mem_d     = '0;
    rsp_valid = 1'b0;
    rsp_mask  = '0;
    rsp_data  = '0;
    if (!rst) begin
      cmd_ready = (state_q == COLLECT) && !block_c;
      rsp_valid = rsp_valid_q;
      rsp_mask  = rsp_mask_q;
      rsp_data  = rsp_data_q;
      if (state_q == ISSUE) begin
        for (int j = 0; j < PORTS; j++) begin
          if (occ_q[j]) begin
            mem_addr[j*AW +: AW]    = AW'(slot_q[j].addr);
            mem_en[j]               = slot_q[j].we;
            mem_d[j*WIDTH +: WIDTH] = WIDTH'(slot_q[j].wdata);
          end
        end
      end
    end
  end

  // Bundle storage
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      occ_q  <= '0;
    end else begin
      slot_q <= slot_d;
      occ_q  <= occ_d;
    end
  end

  // Read-mask pipe tracking reads in flight through the memory
  always_ff @(posedge clk) begin
    if (rst) begin
      rmask_q <= '0;
    end else begin
      rmask_q[0] <= (state_q == ISSUE) ? rd_now_c : '0;
      for (int s = 1; s < LAT; s++) rmask_q[s] <= rmask_q[s-1];
    end
  end

  // mem_q slots that belong to the arriving bundle's reads
  always_comb begin
    rsp_data_c = '0;
    for (int j = 0; j < PORTS; j++) begin
      if (rmask_q[LAT-1][j]) rsp_data_c[j*WIDTH +: WIDTH] = mem_q[j*WIDTH +: WIDTH];
    end
  end

  // Response register, strobed only for bundles that carried reads
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_mask_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= |rmask_q[LAT-1];
      rsp_mask_q  <= rmask_q[LAT-1];
      rsp_data_q  <= rsp_data_c;
    end
  end

endmodule

// File: tb/tb_lvt_cmd_packer.sv
// Randomized and directed bench for lvt_cmd_packer against a timestamp-based model.
module tb_lvt_cmd_packer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned PORTS = 8;
  localparam int unsigned LAT   = 3;
  localparam int unsigned AW    = 9;
  localparam int unsigned PW    = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cmd_valid, cmd_ready, cmd_we, cmd_last;
  logic [PW-1:0]          cmd_port;
  logic [AW-1:0]          cmd_addr;
  logic [WIDTH-1:0]       cmd_wdata;
  logic [PORTS*AW-1:0]    mem_addr;
  logic [PORTS-1:0]       mem_en;
  logic [PORTS*WIDTH-1:0] mem_d, mem_q;
  logic                   rsp_valid;
  logic [PORTS-1:0]       rsp_mask;
  logic [PORTS*WIDTH-1:0] rsp_data;

  always #5 clk = ~clk;

  lvt_cmd_packer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS), .LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_port(cmd_port),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_last(cmd_last),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_d(mem_d), .mem_q(mem_q),
    .rsp_valid(rsp_valid), .rsp_mask(rsp_mask), .rsp_data(rsp_data)
  );

  // Stimulus entries: kind 0 = command, 1 = idle cycle, 2 = reset cycle
  typedef struct {
    int          kind;
    int          port;
    bit          we;
    int          addr;
    logic [31:0] wd;
    bit          last;
  } stim_t;
  typedef struct { int cyc; int addr; } wlog_t;
  typedef struct { int due; logic [7:0] mask; logic [255:0] data; } rsp_t;
  typedef enum int { M_COLLECT, M_HOLD, M_ISSUE } mphase_e;

  stim_t       sq[$];
  wlog_t       wlog[$];
  rsp_t        rq[$];
  bit          m_occ[PORTS];
  bit          m_we[PORTS];
  int          m_addr[PORTS];
  logic [31:0] m_wd[PORTS];
  mphase_e     m_ph;

  int          cyc_n, n_checks, n_errors;
  int          obs_rsp_cnt, obs_en_cnt, t_w, t_r;
  logic [7:0]  obs_last_mask, obs_first_en;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
    end
  endtask

  // Memory read data is a known function of the sampling cycle
  function automatic logic [255:0] memq_at(input int c);
    logic [255:0] v;
    for (int i = 0; i < PORTS; i++) v[i*32 +: 32] = (32'(c) * 32'h9E3779B1) ^ {24'(i), 8'hC3};
    return v;
  endfunction

  function automatic bit m_blocked(input int p, input bit we, input int a);
    bit b = m_occ[p];
    for (int j = 0; j < PORTS; j++)
      if (m_occ[j] && m_addr[j] == a && (we || m_we[j])) b = 1'b1;
    return b;
  endfunction

  // Read in the bundle hits a write issued 1..LAT cycles before cycle c
  function automatic bit m_hazard(input int c);
    for (int j = 0; j < PORTS; j++)
      if (m_occ[j] && !m_we[j])
        foreach (wlog[k])
          if (wlog[k].addr == m_addr[j] && (c - wlog[k].cyc) >= 1 && (c - wlog[k].cyc) <= LAT)
            return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_cmd(input int p, input bit we, input int a, input logic [31:0] d, input bit last);
    stim_t s;
    s.kind = 0; s.port = p; s.we = we; s.addr = a; s.wd = we ? d : 32'h0; s.last = last;
    sq.push_back(s);
  endtask

  task automatic push_other(input int kind, input int n);
    stim_t s;
    s.kind = kind; s.port = 0; s.we = 1'b0; s.addr = 0; s.wd = '0; s.last = 1'b0;
    repeat (n) sq.push_back(s);
  endtask

  task automatic one_cycle();
    stim_t        s;
    bit           have, consumed, e_ready, e_rv, leave;
    logic [71:0]  e_addr;
    logic [7:0]   e_en, e_rm, mask;
    logic [255:0] e_d, e_rd, data;
    @(negedge clk);
    have = (sq.size() > 0);
    if (have) s = sq[0];
    else begin
      s.kind = 1; s.port = 0; s.we = 1'b0; s.addr = 0; s.wd = '0; s.last = 1'b0;
    end
    rst       = (s.kind == 2);
    cmd_valid = (s.kind == 0);
    cmd_port  = PW'(s.port);
    cmd_we    = s.we;
    cmd_addr  = AW'(s.addr);
    cmd_wdata = s.wd;
    cmd_last  = s.last;
    mem_q     = memq_at(cyc_n);
    #1;
    // Expected outputs for this cycle
    e_ready = 1'b0; e_addr = '0; e_en = '0; e_d = '0; e_rv = 1'b0; e_rm = '0; e_rd = '0;
    if (!rst) begin
      e_ready = (m_ph == M_COLLECT) && !m_blocked(s.port, s.we, s.addr);
      if (m_ph == M_ISSUE)
        for (int j = 0; j < PORTS; j++)
          if (m_occ[j]) begin
            e_addr[j*AW +: AW] = AW'(m_addr[j]);
            e_en[j]            = m_we[j];
            e_d[j*32 +: 32]    = m_wd[j];
          end
      if (rq.size() > 0 && rq[0].due == cyc_n) begin
        e_rv = 1'b1; e_rm = rq[0].mask; e_rd = rq[0].data;
      end
    end
    check_eq("cmd_ready", 256'(cmd_ready), 256'(e_ready));
    check_eq("mem_addr",  256'(mem_addr),  256'(e_addr));
    check_eq("mem_en",    256'(mem_en),    256'(e_en));
    check_eq("mem_d",     256'(mem_d),     e_d);
    check_eq("rsp_valid", 256'(rsp_valid), 256'(e_rv));
    check_eq("rsp_mask",  256'(rsp_mask),  256'(e_rm));
    check_eq("rsp_data",  256'(rsp_data),  e_rd);
    // Observations for scenario-level checks
    if (rsp_valid) begin obs_rsp_cnt++; obs_last_mask = rsp_mask; end
    if (mem_en != '0) begin
      if (obs_en_cnt == 0) obs_first_en = mem_en;
      obs_en_cnt++;
    end
    if (mem_en[1]) t_w = cyc_n;
    if (mem_addr[2*AW +: AW] == AW'(7) && !mem_en[2]) t_r = cyc_n;
    // Advance the model across the coming clock edge
    consumed = (s.kind != 0);
    if (rst) begin
      for (int j = 0; j < PORTS; j++) m_occ[j] = 1'b0;
      wlog.delete(); rq.delete(); m_ph = M_COLLECT;
    end else begin
      if (rq.size() > 0 && rq[0].due == cyc_n) void'(rq.pop_front());
      case (m_ph)
        M_COLLECT: begin
          leave = 1'b0;
          if (s.kind == 0) begin
            if (!m_blocked(s.port, s.we, s.addr)) begin
              m_occ[s.port] = 1'b1; m_we[s.port] = s.we;
              m_addr[s.port] = s.addr; m_wd[s.port] = s.wd;
              consumed = 1'b1;
              leave = s.last;
            end else leave = 1'b1;
          end else begin
            for (int j = 0; j < PORTS; j++) if (m_occ[j]) leave = 1'b1;
          end
          if (leave) m_ph = m_hazard(cyc_n) ? M_HOLD : M_ISSUE;
        end
        M_HOLD: if (!m_hazard(cyc_n)) m_ph = M_ISSUE;
        default: begin
          mask = '0; data = memq_at(cyc_n + LAT);
          for (int j = 0; j < PORTS; j++) begin
            if (m_occ[j] && m_we[j]) wlog.push_back('{cyc: cyc_n, addr: m_addr[j]});
            if (m_occ[j] && !m_we[j]) mask[j] = 1'b1;
            if (!(m_occ[j] && !m_we[j])) data[j*32 +: 32] = '0;
            m_occ[j] = 1'b0;
          end
          if (mask != '0) rq.push_back('{due: cyc_n + LAT + 1, mask: mask, data: data});
          m_ph = M_COLLECT;
        end
      endcase
      while (wlog.size() > 0 && (cyc_n - wlog[0].cyc) > LAT) void'(wlog.pop_front());
    end
    if (have && consumed) void'(sq.pop_front());
    cyc_n++;
  endtask

  task automatic run(input int drain);
    int guard = 0;
    while ((sq.size() > 0 || drain > 0) && guard < 5000) begin
      if (sq.size() == 0) drain--;
      one_cycle();
      guard++;
    end
    if (guard >= 5000) begin
      n_checks++; n_errors++;
      $display("FAIL run_budget: %0d entries still queued after %0d cycles", sq.size(), guard);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_port = '0; cmd_we = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_last = 1'b0; mem_q = '0;
    cyc_n = 0; n_checks = 0; n_errors = 0;
    obs_rsp_cnt = 0; obs_en_cnt = 0; t_w = -1; t_r = -1;
    obs_last_mask = '0; obs_first_en = '0;
    for (int j = 0; j < PORTS; j++) begin
      m_occ[j] = 1'b0; m_we[j] = 1'b0; m_addr[j] = 0; m_wd[j] = '0;
    end
    m_ph = M_COLLECT;

    // Reset state, then idle
    push_other(2, 2);
    run(3);

    // Write then read of the same address after two idle cycles
    obs_rsp_cnt = 0;
    push_cmd(0, 1'b1, 5, 32'hA5A5A5A5, 1'b1);
    push_other(1, 2);
    push_cmd(3, 1'b0, 5, 32'h0, 1'b1);
    run(12);
    check_eq("t1_rsp_count", 256'(obs_rsp_cnt), 256'(1));
    check_eq("t1_rsp_mask", 256'(obs_last_mask), 256'(8'h08));

    // Read immediately behind a write to the same address must wait out the pipe
    t_w = -1; t_r = -1;
    push_cmd(1, 1'b1, 7, 32'h1234_5678, 1'b1);
    push_cmd(2, 1'b0, 7, 32'h0, 1'b1);
    run(12);
    check_eq("t2_issue_gap", 256'(t_r - t_w), 256'(LAT + 2));

    // Slot collision closes the bundle
    obs_en_cnt = 0;
    push_cmd(0, 1'b1, 10, 32'h0000_0010, 1'b0);
    push_cmd(1, 1'b1, 11, 32'h0000_0011, 1'b0);
    push_cmd(0, 1'b1, 12, 32'h0000_0012, 1'b0);
    run(10);
    check_eq("t3_first_en", 256'(obs_first_en), 256'(8'h03));
    check_eq("t3_issue_count", 256'(obs_en_cnt), 256'(2));

    // Same-address writes split into two bundles
    obs_en_cnt = 0;
    push_cmd(2, 1'b1, 9, 32'hDEAD_0002, 1'b0);
    push_cmd(4, 1'b1, 9, 32'hDEAD_0004, 1'b1);
    run(10);
    check_eq("t4_first_en", 256'(obs_first_en), 256'(8'h04));
    check_eq("t4_issue_count", 256'(obs_en_cnt), 256'(2));

    // Full eight-read bundle
    obs_rsp_cnt = 0;
    for (int p = 0; p < PORTS; p++) push_cmd(p, 1'b0, p, 32'h0, p == PORTS - 1);
    run(12);
    check_eq("t5_rsp_count", 256'(obs_rsp_cnt), 256'(1));
    check_eq("t5_rsp_mask", 256'(obs_last_mask), 256'(8'hFF));

    // Reset drops a half-built bundle and an in-flight read
    push_cmd(0, 1'b0, 1, 32'h0, 1'b1);
    push_cmd(1, 1'b1, 2, 32'hBEEF_0001, 1'b0);
    push_cmd(2, 1'b1, 3, 32'hBEEF_0002, 1'b0);
    obs_rsp_cnt = 0;
    run(0);
    obs_en_cnt = 0;
    push_other(2, 1);
    run(10);
    check_eq("t6_rsp_count", 256'(obs_rsp_cnt), 256'(0));
    check_eq("t6_issue_count", 256'(obs_en_cnt), 256'(0));

    // Random traffic over a small address range to provoke blocks and hazards
    repeat (400) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) push_other(2, 1);
      else if (r < 20) push_other(1, int'($urandom_range(1, 3)));
      else push_cmd(int'($urandom_range(0, PORTS - 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) == 0);
    end
    run(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
